// File: rtl/multicycle_control.sv
// Moore control FSM for the multi-cycle RV32I-subset datapath (fetch/decode/execute/mem/writeback).
// Latency with mem_ready=1: R/I 4 cycles, LOAD 5, STORE 4, BRANCH 3; outputs decoded from state.
// Stalls in FETCH/MEM_RD/MEM_WR while mem_ready=0; watchdog halts with bus_error. Optional ILLEGAL_TRAP_EN.
module multicycle_control #(
  parameter int MEM_TIMEOUT = 16,
  parameter int ALUOP_W     = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         opcode,
  input  logic               funct3_0,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               ir_write,
  output logic               reg_write,
  output logic               mem_read,
  output logic               mem_write,
  output logic               iord,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               mem_to_reg,
  output logic               pc_src,
  output logic               halted,
`ifdef ILLEGAL_TRAP_EN
  output logic               illegal_instr,
`endif
  output logic               bus_error
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // Counter only needs to reach MEM_TIMEOUT-1; a disabled watchdog keeps a 1-bit dummy.
  localparam int CNT_W  = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam int LAST_I = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
  localparam logic [CNT_W-1:0] LAST = LAST_I[CNT_W-1:0];

  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR,
    WB_ALU, WB_MEM, BRANCH, HALT
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] wait_cnt;
  logic             in_wait;
  logic             wd_trip;
  logic             illegal_hit;

  // Watchdog fires on the last allowed not-ready cycle of a memory wait state.
  always_comb begin
    in_wait = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
    wd_trip = (MEM_TIMEOUT != 0) && in_wait && !mem_ready && (wait_cnt == LAST);
  end

  // State register; reset wins over every transition.
  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_n;
  end

  // Wait counter restarts on any transition and counts stalled memory cycles.
  always_ff @(posedge clk) begin
    if (reset)                     wait_cnt <= '0;
    else if (state_n != state)     wait_cnt <= '0;
    else if (in_wait && !mem_ready) wait_cnt <= wait_cnt + 1'b1;
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus_error <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
      illegal_instr <= 1'b0;
`endif
    end else begin
      if (wd_trip) bus_error <= 1'b1;
`ifdef ILLEGAL_TRAP_EN
      if (illegal_hit) illegal_instr <= 1'b1;
`endif
    end
  end

  // Next-state and Moore output decode; only FETCH and BRANCH qualify pc_write/ir_write by inputs.
  always_comb begin
    state_n     = state;
    illegal_hit = 1'b0;
    pc_write    = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    iord        = 1'b0;
    alu_src_a   = 2'd0;
    alu_src_b   = 2'd0;
    ALUOp       = ALUOP_W'(0);
    mem_to_reg  = 1'b0;
    pc_src      = 1'b0;
    halted      = 1'b0;
    case (state)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'd1;
        ALUOp     = ALUOP_W'(3);
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready)    state_n = DECODE;
        else if (wd_trip) state_n = HALT;
      end
      DECODE: begin
        // Speculatively compute the branch target into ALUOut.
        alu_src_a = 2'd2;
        alu_src_b = 2'd2;
        ALUOp     = ALUOP_W'(3);
        case (opcode)
          OP_R:               state_n = EXEC_R;
          OP_I:               state_n = EXEC_I;
          OP_LOAD, OP_STORE:  state_n = MEM_ADDR;
          OP_BRANCH:          state_n = BRANCH;
          default: begin
`ifdef ILLEGAL_TRAP_EN
            state_n     = HALT;
            illegal_hit = 1'b1;
`else
            state_n     = FETCH;
`endif
          end
        endcase
      end
      EXEC_R: begin
        alu_src_a = 2'd1;
        alu_src_b = 2'd0;
        ALUOp     = ALUOP_W'(1);
        state_n   = WB_ALU;
      end
      EXEC_I: begin
        alu_src_a = 2'd1;
        alu_src_b = 2'd2;
        ALUOp     = ALUOP_W'(1);
        state_n   = WB_ALU;
      end
      MEM_ADDR: begin
        // IR still holds the instruction, so the opcode selects load vs store here.
        alu_src_a = 2'd1;
        alu_src_b = 2'd2;
        ALUOp     = ALUOP_W'(3);
        state_n   = (opcode == OP_LOAD) ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready)    state_n = WB_MEM;
        else if (wd_trip) state_n = HALT;
      end
      MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready)    state_n = FETCH;
        else if (wd_trip) state_n = HALT;
      end
      WB_ALU: begin
        reg_write = 1'b1;
        state_n   = FETCH;
      end
      WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_n    = FETCH;
      end
      BRANCH: begin
        alu_src_a = 2'd1;
        alu_src_b = 2'd0;
        ALUOp     = ALUOP_W'(2);
        pc_src    = 1'b1;
        pc_write  = funct3_0 ? ~zero : zero;
        state_n   = FETCH;
      end
      HALT: begin
        halted  = 1'b1;
        state_n = HALT;
      end
      default: state_n = FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] opcode = 7'b0110011;
  logic       funct3_0 = 1'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, ir_write, reg_write, mem_read, mem_write, iord;
  logic [1:0] alu_src_a, alu_src_b;
  logic [3:0] ALUOp;
  logic       mem_to_reg, pc_src, halted, bus_error;
`ifdef ILLEGAL_TRAP_EN
  logic       illegal_instr;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_control #(.MEM_TIMEOUT(4), .ALUOP_W(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3_0(funct3_0), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .ALUOp(ALUOp), .mem_to_reg(mem_to_reg), .pc_src(pc_src),
    .halted(halted),
`ifdef ILLEGAL_TRAP_EN
    .illegal_instr(illegal_instr),
`endif
    .bus_error(bus_error)
  );

  // Field order: pcw irw rw mr mw iord a[2] b[2] op[4] m2r psrc halted bus_error
  logic [17:0] outs;
  assign outs = {pc_write, ir_write, reg_write, mem_read, mem_write, iord,
                 alu_src_a, alu_src_b, ALUOp, mem_to_reg, pc_src, halted, bus_error};

  function automatic logic [17:0] ov(input logic pcw, irw, rw, mr, mw, io,
                                     input logic [1:0] a, b, input logic [3:0] op,
                                     input logic m2r, ps, h, be);
    return {pcw, irw, rw, mr, mw, io, a, b, op, m2r, ps, h, be};
  endfunction

  logic [17:0] FETCH0, FETCH1, DEC, EXR, EXI, MADDR, MRD, MWR, WBA, WBM, BR_T, BR_N, HALT_BE, HALT_OK;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mem_ready = 1'b0;
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mem_ready = 1'b0;
    cyc();
    #1;
    checks++;
    if (outs !== FETCH0) begin
      errors++;
      $display("FAIL reset_state: got %h want %h", outs, FETCH0);
    end
    reset = 1'b0;
  endtask

  task automatic test_rtype();
    logic [17:0] e [0:4];
    e[0] = FETCH1; e[1] = DEC; e[2] = EXR; e[3] = WBA; e[4] = FETCH1;
    do_reset();
    opcode = 7'b0110011;
    mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (outs !== e[i]) begin
        errors++;
        $display("FAIL rtype cyc%0d: got %h want %h", i, outs, e[i]);
      end
      cyc();
    end
  endtask

  task automatic test_itype();
    logic [17:0] e [0:4];
    e[0] = FETCH1; e[1] = DEC; e[2] = EXI; e[3] = WBA; e[4] = FETCH1;
    do_reset();
    opcode = 7'b0010011;
    mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (outs !== e[i]) begin
        errors++;
        $display("FAIL itype cyc%0d: got %h want %h", i, outs, e[i]);
      end
      cyc();
    end
  endtask

  task automatic test_load();
    logic [17:0] e [0:8];
    logic        r [0:8];
    e[0] = FETCH1; e[1] = DEC; e[2] = MADDR; e[3] = MRD; e[4] = MRD;
    e[5] = MRD; e[6] = MRD; e[7] = WBM; e[8] = FETCH1;
    r[0] = 1; r[1] = 1; r[2] = 1; r[3] = 0; r[4] = 0; r[5] = 0; r[6] = 1; r[7] = 1; r[8] = 1;
    do_reset();
    opcode = 7'b0000011;
    for (int i = 0; i < 9; i++) begin
      mem_ready = r[i];
      #1;
      checks++;
      if (outs !== e[i]) begin
        errors++;
        $display("FAIL load cyc%0d: got %h want %h", i, outs, e[i]);
      end
      cyc();
    end
  endtask

  task automatic test_store();
    logic [17:0] e [0:4];
    e[0] = FETCH1; e[1] = DEC; e[2] = MADDR; e[3] = MWR; e[4] = FETCH1;
    do_reset();
    opcode = 7'b0100011;
    mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (outs !== e[i]) begin
        errors++;
        $display("FAIL store cyc%0d: got %h want %h", i, outs, e[i]);
      end
      cyc();
    end
  endtask

  task automatic test_branch();
    logic [17:0] e [0:3];
    logic        f [0:2];
    logic        z [0:2];
    // BEQ taken, BNE not taken, BEQ not taken
    f[0] = 0; z[0] = 1;
    f[1] = 1; z[1] = 1;
    f[2] = 0; z[2] = 0;
    for (int k = 0; k < 3; k++) begin
      e[0] = FETCH1; e[1] = DEC; e[2] = (k == 0) ? BR_T : BR_N; e[3] = FETCH1;
      do_reset();
      opcode = 7'b1100011;
      funct3_0 = f[k];
      zero = z[k];
      mem_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
        #1;
        checks++;
        if (outs !== e[i]) begin
          errors++;
          $display("FAIL branch%0d cyc%0d: got %h want %h", k, i, outs, e[i]);
        end
        cyc();
      end
    end
    zero = 1'b0;
    funct3_0 = 1'b0;
  endtask

  task automatic test_illegal();
    logic [17:0] e [0:3];
    e[0] = FETCH1; e[1] = DEC;
`ifdef ILLEGAL_TRAP_EN
    e[2] = HALT_OK; e[3] = HALT_OK;
`else
    e[2] = FETCH1; e[3] = DEC;
`endif
    do_reset();
    opcode = 7'b1111111;
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (outs !== e[i]) begin
        errors++;
        $display("FAIL illegal cyc%0d: got %h want %h", i, outs, e[i]);
      end
`ifdef ILLEGAL_TRAP_EN
      if (i >= 2) begin
        checks++;
        if (illegal_instr !== 1'b1) begin
          errors++;
          $display("FAIL illegal_flag cyc%0d: got %b want 1", i, illegal_instr);
        end
      end
`endif
      cyc();
    end
  endtask

  task automatic test_watchdog();
    do_reset();
    opcode = 7'b0110011;
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (outs !== FETCH0) begin
        errors++;
        $display("FAIL wd_wait cyc%0d: got %h want %h", i, outs, FETCH0);
      end
      cyc();
    end
    for (int i = 0; i < 20; i++) begin
      #1;
      checks++;
      if (outs !== HALT_BE) begin
        errors++;
        $display("FAIL wd_halt cyc%0d: got %h want %h", i, outs, HALT_BE);
      end
      cyc();
    end
    do_reset();
    #1;
    checks++;
    if (outs !== FETCH0) begin
      errors++;
      $display("FAIL wd_recover: got %h want %h", outs, FETCH0);
    end
    // Ready arrives on the 4th wait cycle: must beat the timeout.
    for (int i = 0; i < 3; i++) cyc();
    mem_ready = 1'b1;
    #1;
    checks++;
    if (outs !== FETCH1) begin
      errors++;
      $display("FAIL wd_last_ready: got %h want %h", outs, FETCH1);
    end
    cyc();
    #1;
    checks++;
    if (outs !== DEC) begin
      errors++;
      $display("FAIL wd_no_error: got %h want %h", outs, DEC);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    opcode = 7'b0100011;
    mem_ready = 1'b1;
    cyc(); cyc(); cyc();
    mem_ready = 1'b0;
    cyc();
    #1;
    checks++;
    if (outs !== MWR) begin
      errors++;
      $display("FAIL mid_memwr: got %h want %h", outs, MWR);
    end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    // Counter must restart: four full stall cycles in FETCH, then HALT.
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (outs !== FETCH0) begin
        errors++;
        $display("FAIL mid_fetch cyc%0d: got %h want %h", i, outs, FETCH0);
      end
      cyc();
    end
    #1;
    checks++;
    if (outs !== HALT_BE) begin
      errors++;
      $display("FAIL mid_halt: got %h want %h", outs, HALT_BE);
    end
    do_reset();
  endtask

  initial begin
    FETCH0  = ov(0,0,0,1,0,0, 2'd0,2'd1,4'd3, 0,0,0,0);
    FETCH1  = ov(1,1,0,1,0,0, 2'd0,2'd1,4'd3, 0,0,0,0);
    DEC     = ov(0,0,0,0,0,0, 2'd2,2'd2,4'd3, 0,0,0,0);
    EXR     = ov(0,0,0,0,0,0, 2'd1,2'd0,4'd1, 0,0,0,0);
    EXI     = ov(0,0,0,0,0,0, 2'd1,2'd2,4'd1, 0,0,0,0);
    MADDR   = ov(0,0,0,0,0,0, 2'd1,2'd2,4'd3, 0,0,0,0);
    MRD     = ov(0,0,0,1,0,1, 2'd0,2'd0,4'd0, 0,0,0,0);
    MWR     = ov(0,0,0,0,1,1, 2'd0,2'd0,4'd0, 0,0,0,0);
    WBA     = ov(0,0,1,0,0,0, 2'd0,2'd0,4'd0, 0,0,0,0);
    WBM     = ov(0,0,1,0,0,0, 2'd0,2'd0,4'd0, 1,0,0,0);
    BR_T    = ov(1,0,0,0,0,0, 2'd1,2'd0,4'd2, 0,1,0,0);
    BR_N    = ov(0,0,0,0,0,0, 2'd1,2'd0,4'd2, 0,1,0,0);
    HALT_BE = ov(0,0,0,0,0,0, 2'd0,2'd0,4'd0, 0,0,1,1);
    HALT_OK = ov(0,0,0,0,0,0, 2'd0,2'd0,4'd0, 0,0,1,0);

    test_reset();
    test_rtype();
    test_itype();
    test_load();
    test_store();
    test_branch();
    test_illegal();
    test_watchdog();
    test_reset_mid();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
